// File: rtl/sm3_pkg.sv
// Shared SM3 padding definitions: pad FSM states, block geometry and last-word helpers.
package sm3_pkg;

  localparam int SM3_BLK_WORDS = 16;
  localparam int SM3_IDX_W     = $clog2(SM3_BLK_WORDS);
  localparam logic [SM3_IDX_W-1:0] SM3_LEN_IDX = SM3_IDX_W'(14);
  localparam logic [7:0] SM3_PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    PAD80,
    ZERO,
    LEN_H,
    LEN_L
  } pad_state_e;

  // Keeps the valid leading bytes of a partial last word and appends the 0x80 marker.
  function automatic logic [31:0] sm3_pad_last(input logic [31:0] d, input logic [3:0] mask);
    case (mask)
      4'b1000: return {d[31:24], SM3_PAD_BYTE, 16'h0000};
      4'b1100: return {d[31:16], SM3_PAD_BYTE, 8'h00};
      4'b1110: return {d[31:8], SM3_PAD_BYTE};
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] sm3_last_bits(input logic [3:0] mask);
    case (mask)
      4'b1000: return 64'd8;
      4'b1100: return 64'd16;
      4'b1110: return 64'd24;
      default: return 64'd32;
    endcase
  endfunction

endpackage

// File: rtl/sm3_pad_core.sv
// SM3 message padder: forwards words, appends 0x80, zero fill and 64-bit length.
// Byte-granular last words are enabled by defining SM3_PAD_BYTE_EN.
module sm3_pad_core
  import sm3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] msg_inpt_d_i,
  input  logic        msg_inpt_vld_i,
  input  logic        msg_inpt_lst_i,
`ifdef SM3_PAD_BYTE_EN
  input  logic [3:0]  msg_inpt_vld_byte_i,
`endif
  output logic        msg_inpt_rdy_o,
  input  logic        pad_otpt_ena_i,
  output logic [31:0] pad_otpt_d_o,
  output logic        pad_otpt_vld_o,
  output logic        pad_otpt_lst_o
);

  pad_state_e              r_state, w_state_nxt;
  logic [SM3_IDX_W-1:0]    r_idx, w_idx_nxt, w_idx_inc;
  logic [63:0]             r_len, w_len_nxt;
  logic [31:0]             r_d, w_d_nxt;
  logic                    r_vld, w_vld_nxt;
  logic                    r_lst, w_lst_nxt;
  logic [3:0]              w_mask;
  logic                    w_load;
  logic                    w_acc;
  logic                    w_at_len;

`ifdef SM3_PAD_BYTE_EN
  assign w_mask = msg_inpt_vld_byte_i;
`else
  assign w_mask = 4'b1111;
`endif

  // The single output stage refills whenever it is empty or being drained.
  assign w_load         = !r_vld || pad_otpt_ena_i;
  assign msg_inpt_rdy_o = (r_state == PASS) && w_load;
  assign w_acc          = msg_inpt_vld_i && msg_inpt_rdy_o;
  assign w_idx_inc      = r_idx + SM3_IDX_W'(1);
  assign w_at_len       = (w_idx_inc == SM3_LEN_IDX);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_d_nxt     = r_d;
    w_vld_nxt   = r_vld && !pad_otpt_ena_i;
    w_lst_nxt   = r_lst && !pad_otpt_ena_i;

    case (r_state)
      IDLE: w_state_nxt = PASS;

      PASS: begin
        if (w_acc) begin
          w_vld_nxt = 1'b1;
          w_lst_nxt = 1'b0;
          w_idx_nxt = w_idx_inc;
          if (msg_inpt_lst_i) begin
            w_d_nxt   = sm3_pad_last(msg_inpt_d_i, w_mask);
            w_len_nxt = r_len + sm3_last_bits(w_mask);
            if (w_mask == 4'b1111) w_state_nxt = PAD80;
            else                   w_state_nxt = w_at_len ? LEN_H : ZERO;
          end else begin
            w_d_nxt   = msg_inpt_d_i;
            w_len_nxt = r_len + 64'd32;
          end
        end
      end

      PAD80: begin
        if (w_load) begin
          w_vld_nxt   = 1'b1;
          w_lst_nxt   = 1'b0;
          w_d_nxt     = {SM3_PAD_BYTE, 24'h000000};
          w_idx_nxt   = w_idx_inc;
          w_state_nxt = w_at_len ? LEN_H : ZERO;
        end
      end

      // Zero fill runs through the index wrap so output stays a whole number of blocks.
      ZERO: begin
        if (w_load) begin
          w_vld_nxt = 1'b1;
          w_lst_nxt = 1'b0;
          w_d_nxt   = 32'h0000_0000;
          w_idx_nxt = w_idx_inc;
          if (w_at_len) w_state_nxt = LEN_H;
        end
      end

      LEN_H: begin
        if (w_load) begin
          w_vld_nxt   = 1'b1;
          w_lst_nxt   = 1'b0;
          w_d_nxt     = r_len[63:32];
          w_idx_nxt   = w_idx_inc;
          w_state_nxt = LEN_L;
        end
      end

      LEN_L: begin
        if (w_load) begin
          w_vld_nxt   = 1'b1;
          w_lst_nxt   = 1'b1;
          w_d_nxt     = r_len[31:0];
          w_idx_nxt   = '0;
          w_len_nxt   = '0;
          w_state_nxt = PASS;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_d     <= '0;
      r_vld   <= 1'b0;
      r_lst   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_d     <= w_d_nxt;
      r_vld   <= w_vld_nxt;
      r_lst   <= w_lst_nxt;
    end
  end

  assign pad_otpt_d_o   = r_d;
  assign pad_otpt_vld_o = r_vld;
  assign pad_otpt_lst_o = r_lst;

endmodule

// File: tb/tb_sm3_pad_core.sv
// Self-checking bench for sm3_pad_core: byte-stream padding model, random backpressure, reset cases.
module tb_sm3_pad_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] msg_inpt_d_i;
  logic        msg_inpt_vld_i;
  logic        msg_inpt_lst_i;
  logic [3:0]  msg_inpt_vld_byte_i;
  logic        msg_inpt_rdy_o;
  logic        pad_otpt_ena_i;
  logic [31:0] pad_otpt_d_o;
  logic        pad_otpt_vld_o;
  logic        pad_otpt_lst_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] msg_q[$];
  logic [3:0]  cur_mask;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sm3_pad_core dut (
    .clk                 (clk),
    .rst                 (rst),
    .msg_inpt_d_i        (msg_inpt_d_i),
    .msg_inpt_vld_i      (msg_inpt_vld_i),
    .msg_inpt_lst_i      (msg_inpt_lst_i),
`ifdef SM3_PAD_BYTE_EN
    .msg_inpt_vld_byte_i (msg_inpt_vld_byte_i),
`endif
    .msg_inpt_rdy_o      (msg_inpt_rdy_o),
    .pad_otpt_ena_i      (pad_otpt_ena_i),
    .pad_otpt_d_o        (pad_otpt_d_o),
    .pad_otpt_vld_o      (pad_otpt_vld_o),
    .pad_otpt_lst_o      (pad_otpt_lst_o)
  );

  function automatic logic [3:0] eff_mask(input logic [3:0] m);
`ifdef SM3_PAD_BYTE_EN
    return m;
`else
    return 4'b1111;
`endif
  endfunction

  // Reference: flatten to bytes, add 0x80, zero to 56 mod 64, append 64-bit bit count.
  task automatic build_expected();
    byte unsigned     b[$];
    longint unsigned  bits;
    int               nb;
    logic [31:0]      w;
    exp_q.delete();
    for (int i = 0; i < msg_q.size(); i++) begin
      nb = (i == msg_q.size() - 1) ? $countones(eff_mask(cur_mask)) : 4;
      w  = msg_q[i];
      for (int k = 0; k < nb; k++) b.push_back(w[31-8*k -: 8]);
    end
    bits = 64'(b.size()) * 64'd8;
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    for (int k = 7; k >= 0; k--) b.push_back(8'(bits >> (8*k)));
    for (int i = 0; i < b.size(); i += 4)
      exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
  endtask

  // Streams msg_q through the DUT with bp_pct% ena-low cycles; abort_after>0 stops early.
  task automatic run_msg(input int bp_pct, input int abort_after, input string name);
    int          sent = 0, got = 0, cyc = 0;
    bit          done = 0, last_acc = 0, acc_prev = 0, prev_hold = 0;
    logic [31:0] prev_d;
    logic        prev_lst;
    build_expected();
    while (!done) begin
      @(negedge clk);
      pad_otpt_ena_i = ($urandom_range(99) >= bp_pct);
      if (sent < msg_q.size()) begin
        msg_inpt_vld_i      = 1'b1;
        msg_inpt_d_i        = msg_q[sent];
        msg_inpt_lst_i      = (sent == msg_q.size() - 1);
        msg_inpt_vld_byte_i = msg_inpt_lst_i ? cur_mask : 4'($urandom);
      end else begin
        msg_inpt_vld_i      = 1'b0;
        msg_inpt_lst_i      = 1'b0;
        msg_inpt_d_i        = $urandom;
        msg_inpt_vld_byte_i = 4'($urandom);
      end
      #1;
      if (acc_prev) begin
        checks++;
        if (pad_otpt_vld_o !== 1'b1) begin
          errors++;
          $display("FAIL %s latency: vld=%b required 1 one cycle after accept", name, pad_otpt_vld_o);
        end
      end
      if (prev_hold) begin
        checks++;
        if (pad_otpt_vld_o !== 1'b1 || pad_otpt_d_o !== prev_d || pad_otpt_lst_o !== prev_lst) begin
          errors++;
          $display("FAIL %s hold: vld=%b d=%h lst=%b required vld=1 d=%h lst=%b",
                   name, pad_otpt_vld_o, pad_otpt_d_o, pad_otpt_lst_o, prev_d, prev_lst);
        end
      end
      if (last_acc && !pad_otpt_lst_o) begin
        checks++;
        if (msg_inpt_rdy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s rdy_after_last: rdy=%b required 0", name, msg_inpt_rdy_o);
        end
      end
      acc_prev = msg_inpt_vld_i && msg_inpt_rdy_o;
      if (pad_otpt_vld_o && pad_otpt_ena_i) begin
        checks++;
        if (got >= exp_q.size() || pad_otpt_d_o !== exp_q[got]) begin
          errors++;
          $display("FAIL %s word[%0d]: got %h required %h", name, got, pad_otpt_d_o,
                   (got < exp_q.size()) ? exp_q[got] : 32'hxxxx_xxxx);
        end
        checks++;
        if (pad_otpt_lst_o !== (got == exp_q.size() - 1)) begin
          errors++;
          $display("FAIL %s lst[%0d]: got %b required %b", name, got, pad_otpt_lst_o,
                   (got == exp_q.size() - 1));
        end
        got++;
        if (pad_otpt_lst_o || got > exp_q.size()) done = 1;
      end
      prev_hold = pad_otpt_vld_o && !pad_otpt_ena_i;
      prev_d    = pad_otpt_d_o;
      prev_lst  = pad_otpt_lst_o;
      if (acc_prev) begin
        sent++;
        if (msg_inpt_lst_i) last_acc = 1;
      end
      if (abort_after > 0 && got >= abort_after) done = 1;
      cyc++;
      if (cyc > 5000 && !done) begin
        errors++;
        $display("FAIL %s timeout: %0d words seen required %0d", name, got, exp_q.size());
        done = 1;
      end
    end
    if (abort_after == 0) begin
      checks++;
      if (got != exp_q.size()) begin
        errors++;
        $display("FAIL %s word_count: got %0d required %0d", name, got, exp_q.size());
      end
      @(negedge clk);
      msg_inpt_vld_i = 1'b0;
      #1;
      checks++;
      if (pad_otpt_vld_o !== 1'b0) begin
        errors++;
        $display("FAIL %s extra_word: vld=%b d=%h required vld=0", name, pad_otpt_vld_o, pad_otpt_d_o);
      end
    end
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    rst            = 1'b1;
    msg_inpt_vld_i = 1'b0;
    msg_inpt_lst_i = 1'b0;
    pad_otpt_ena_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pad_otpt_vld_o !== 1'b0 || pad_otpt_lst_o !== 1'b0 || pad_otpt_d_o !== 32'h0 ||
        msg_inpt_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_state: vld=%b lst=%b d=%h rdy=%b required 0 0 00000000 0",
               name, pad_otpt_vld_o, pad_otpt_lst_o, pad_otpt_d_o, msg_inpt_rdy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (msg_inpt_rdy_o !== 1'b1 || pad_otpt_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL %s post_reset: rdy=%b vld=%b required rdy=1 vld=0",
               name, msg_inpt_rdy_o, pad_otpt_vld_o);
    end
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_abc();
    msg_q = '{32'h6162_6300};
    cur_mask = 4'b1110;
    run_msg(0, 0, "abc");
  endtask

  task automatic test_full14();
    msg_q.delete();
    for (int i = 1; i <= 14; i++) msg_q.push_back(32'(i));
    cur_mask = 4'b1111;
    run_msg(0, 0, "full14");
  endtask

  task automatic test_partial_last();
    msg_q.delete();
    for (int i = 1; i <= 13; i++) msg_q.push_back($urandom);
    msg_q.push_back(32'hAB00_0000);
    cur_mask = 4'b1000;
    run_msg(0, 0, "mask1000");
  endtask

  task automatic test_backpressure();
    msg_q.delete();
    for (int i = 1; i <= 14; i++) msg_q.push_back(32'(i));
    cur_mask = 4'b1111;
    run_msg(50, 0, "backpressure");
  endtask

  task automatic test_reset_mid();
    msg_q.delete();
    for (int i = 1; i <= 14; i++) msg_q.push_back(32'(i));
    cur_mask = 4'b1111;
    run_msg(0, 20, "pre_reset");
    apply_reset("mid_reset");
    msg_q = '{32'h6162_6300};
    cur_mask = 4'b1110;
    run_msg(30, 0, "abc_after_reset");
  endtask

  task automatic test_random();
    logic [3:0] masks[4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    for (int t = 0; t < 25; t++) begin
      msg_q.delete();
      for (int i = 0; i < $urandom_range(40, 1); i++) msg_q.push_back($urandom);
      cur_mask = masks[$urandom_range(3)];
      run_msg($urandom_range(60), 0, "random");
    end
  endtask

  initial begin
    rst                 = 1'b1;
    msg_inpt_d_i        = '0;
    msg_inpt_vld_i      = 1'b0;
    msg_inpt_lst_i      = 1'b0;
    msg_inpt_vld_byte_i = '0;
    pad_otpt_ena_i      = 1'b1;
    cur_mask            = 4'b1111;
    test_reset();
    test_abc();
    test_full14();
    test_partial_last();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm3_pad_core.md
SM3_PAD_CORE -- requirements
Module: sm3_pad_core

Interface
REQ-001 The block SHALL have these parameters (none; widths fixed): data word 32 bits, length field 64 bits, block 16 words.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- msg_inpt_d_i  in  32  message word, big-endian (byte 0 = [31:24])
- msg_inpt_vld_i  in  1  input word valid
- msg_inpt_lst_i  in  1  final word of message
- msg_inpt_vld_byte_i  in  4  valid-byte mask, sampled with lst only (exists only with SM3_PAD_BYTE_EN)
- msg_inpt_rdy_o  out  1  input word accepted when vld&rdy
- pad_otpt_ena_i  in  1  downstream (expansion) ready
- pad_otpt_d_o  out  32  padded word
- pad_otpt_vld_o  out  1  output word valid
- pad_otpt_lst_o  out  1  final word of final block

Function
REQ-003 The block SHALL transfer an output word only when pad_otpt_vld_o && pad_otpt_ena_i; a held word, including d and lst, SHALL be stable until transferred.
REQ-004 The output SHALL be a single register stage that loads when !pad_otpt_vld_o || pad_otpt_ena_i; msg_inpt_rdy_o = (state==PASS) && that load condition.
REQ-005 The FSM SHALL have states IDLE, PASS, PAD80, ZERO, LEN_H, LEN_L.
- IDLE -> PASS when not in reset.
- PASS: accepted words are forwarded unchanged. The last word is forwarded with 0x80 inserted after its valid bytes and zero-filled; the FSM then goes to ZERO. If the last word is full (mask 4'b1111), the FSM SHALL go to PAD80 instead.
- PAD80 emits 0x80000000 -> ZERO.
- ZERO emits 0x00000000 while word index != 14 -> LEN_H.
- LEN_H emits len[63:32] -> LEN_L.
- LEN_L emits len[31:0] with lst=1 -> PASS, with counters cleared.
REQ-006 The word index SHALL be a 4-bit counter incremented per emitted word, wrapping 15->0. When ZERO is entered at index 15 or 0, zero fill SHALL continue through the wrap into a new block, so the total output is always a multiple of 16 words.
REQ-007 The bit length SHALL be a 64-bit counter: +32 per full word, +8*popcount(mask) for the last word. It SHALL wrap modulo 2^64.
REQ-008 Legal masks SHALL be 1000, 1100, 1110 and 1111. Other masks are undefined; a zero-length message is not supported.
REQ-009 The latency from an accepted input word to its output vld SHALL be 1 cycle. Generated words issue back-to-back without bubbles when ena is high.
REQ-010 pad_otpt_lst_o SHALL be 0 for all words except the LEN_L word.
REQ-011 msg_inpt_rdy_o SHALL be low from the cycle after the last word is accepted until the LEN_L word is loaded into the output register.

Reset
REQ-012 While rst=1 at a clock edge the block SHALL enter IDLE and clear the following: pad_otpt_vld_o, pad_otpt_lst_o, pad_otpt_d_o, msg_inpt_rdy_o, word index and length counter.
REQ-013 Reset mid-message SHALL discard the partial message and any held output word. No lst SHALL be emitted for it.

Configuration
REQ-014 With SM3_PAD_BYTE_EN defined, msg_inpt_vld_byte_i SHALL exist and byte-granular last words SHALL be supported per REQ-005/007.
REQ-015 Without SM3_PAD_BYTE_EN, the port SHALL be absent and every last word SHALL be treated as mask 1111, so the length is always a multiple of 32 bits.

Structure
REQ-016 Shared package sm3_pkg SHALL hold:
- the pad state enum
- SM3_BLK_WORDS=16
- SM3_LEN_IDX=14
- SM3_PAD_BYTE=8'h80
REQ-017 The implementation SHALL be a single module with no sub-module. The FSM, counters and output register SHALL live in sm3_pad_core.

Verification
REQ-018 "abc": one word 0x61626300, mask 1110, lst -> 16 words: 0x61626380, 13x 0x0, 0x00000000, 0x00000018 with lst on word 16.
REQ-019 14 full words (0x01..0x0E), lst on the 14th -> 32 words: word 15 = 0x80000000, words 16-30 = 0, word 31 = 0x00000000, word 32 = 0x000001C0 (lst).
REQ-020 13 full words + last word mask 1000 data 0xAB000000 -> word 14 = 0xAB800000, then 0x00000000 and 0x000001A8 (lst); 16 words total.
REQ-021 Random ena backpressure (~50%) on REQ-019 -> identical word sequence; d/lst held stable while vld&&!ena; no drop or duplicate.
REQ-022 rst pulsed during the ZERO phase, then the "abc" case is sent -> only the REQ-018 sequence appears after reset with length 0x18, with no stale lst.
